// File: rtl/sw_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : sw_operand_loader
// Description : Loads two operands and a carry-in from slide switches using a
//               debounced push-button, then presents them with a handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module sw_operand_loader #(
    parameter int DATA_SIZE       = 4,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DATA_SIZE-1:0] sw_in,
    input  logic                 cin_sw,
    input  logic                 btn_load,
    input  logic                 cons_ready,
    output logic [DATA_SIZE-1:0] a_out,
    output logic [DATA_SIZE-1:0] b_out,
    output logic                 c_out,
    output logic                 operand_valid,
    output logic [1:0]           phase_led
);

    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    // State codes double as the phase LED pattern.
    typedef enum logic [1:0] {
        LOAD_A  = 2'b01,
        LOAD_B  = 2'b10,
        PRESENT = 2'b11
    } state_t;

    logic [DATA_SIZE-1:0] sw_meta_q;
    logic [DATA_SIZE-1:0] sw_sync_q;
    logic                 cin_meta_q;
    logic                 cin_sync_q;
    logic                 btn_meta_q;
    logic                 btn_sync_q;

    logic                 db_q;
    logic                 db_d;
    logic [c_CNT_W-1:0]   cnt_q;
    logic [c_CNT_W-1:0]   cnt_d;
    logic                 press_q;
    logic                 press_d;

    state_t               state_q;
    state_t               state_d;
    logic [DATA_SIZE-1:0] a_q;
    logic [DATA_SIZE-1:0] a_d;
    logic [DATA_SIZE-1:0] b_q;
    logic [DATA_SIZE-1:0] b_d;
    logic                 c_q;
    logic                 c_d;
    logic                 valid_q;
    logic                 valid_d;

    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (btn_sync_q != db_q) begin
            if (cnt_q == c_CNT_LAST) begin
                db_d = btn_sync_q;
            end else begin
                cnt_d = cnt_q + c_CNT_ONE;
            end
        end
        press_d = db_d & ~db_q;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        valid_d = valid_q;
        case (state_q)
            LOAD_A: begin
                if (press_q) begin
                    a_d     = sw_sync_q;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (press_q) begin
                    b_d     = sw_sync_q;
                    c_d     = cin_sync_q;
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                // Presses are dropped here; only the handshake leaves PRESENT.
                if (cons_ready) begin
                    valid_d = 1'b0;
                    state_d = LOAD_A;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = LOAD_A;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            cin_meta_q <= 1'b0;
            cin_sync_q <= 1'b0;
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            db_q       <= 1'b0;
            cnt_q      <= '0;
            press_q    <= 1'b0;
            state_q    <= LOAD_A;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            sw_meta_q  <= sw_in;
            sw_sync_q  <= sw_meta_q;
            cin_meta_q <= cin_sw;
            cin_sync_q <= cin_meta_q;
            btn_meta_q <= btn_load;
            btn_sync_q <= btn_meta_q;
            db_q       <= db_d;
            cnt_q      <= cnt_d;
            press_q    <= press_d;
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            valid_q    <= valid_d;
        end
    end

    assign a_out         = a_q;
    assign b_out         = b_q;
    assign c_out         = c_q;
    assign operand_valid = valid_q;
    assign phase_led     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_sw_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_sw_operand_loader
// Description : Directed bench for sw_operand_loader with a cycle-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sw_operand_loader;

    localparam int DS = 4;
    localparam int DB = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DS-1:0] sw_in = '0;
    logic          cin_sw = 1'b0;
    logic          btn_load = 1'b0;
    logic          cons_ready = 1'b0;
    logic [DS-1:0] a_out;
    logic [DS-1:0] b_out;
    logic          c_out;
    logic          operand_valid;
    logic [1:0]    phase_led;

    always #5 clk = ~clk;

    sw_operand_loader #(
        .DATA_SIZE       (DS),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .sw_in         (sw_in),
        .cin_sw        (cin_sw),
        .btn_load      (btn_load),
        .cons_ready    (cons_ready),
        .a_out         (a_out),
        .b_out         (b_out),
        .c_out         (c_out),
        .operand_valid (operand_valid),
        .phase_led     (phase_led)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: inputs are seen two edges late; the button level flips after DB
    // consecutive disagreeing cycles; a rising flip yields an event next edge.
    logic [DS-1:0] m_sw1, m_sw2, m_a, m_b;
    logic          m_c1, m_c2, m_k1, m_k2, m_level, m_ev, m_c, m_new_ev;
    int            m_run, m_phase;

    always @(posedge clk) begin
        if (!reset_n) begin
            {m_sw1, m_sw2, m_a, m_b} = '0;
            {m_c1, m_c2, m_k1, m_k2, m_level, m_ev, m_c} = '0;
            m_run   = 0;
            m_phase = 0;
        end else begin
            if (m_phase == 0 && m_ev) begin
                m_a     = m_sw2;
                m_phase = 1;
            end else if (m_phase == 1 && m_ev) begin
                m_b     = m_sw2;
                m_c     = m_c2;
                m_phase = 2;
            end else if (m_phase == 2 && cons_ready) begin
                m_phase = 0;
            end
            m_new_ev = 1'b0;
            if (m_k2 != m_level) begin
                m_run++;
                if (m_run == DB) begin
                    m_level  = m_k2;
                    m_run    = 0;
                    m_new_ev = m_level;
                end
            end else begin
                m_run = 0;
            end
            m_ev  = m_new_ev;
            m_sw2 = m_sw1;  m_sw1 = sw_in;
            m_c2  = m_c1;   m_c1  = cin_sw;
            m_k2  = m_k1;   m_k1  = btn_load;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_a_out", a_out, m_a);
            check("model_b_out", b_out, m_b);
            check("model_c_out", c_out, m_c);
            check("model_valid", operand_valid, (m_phase == 2) ? 1 : 0);
            check("model_phase", phase_led, m_phase + 1);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press();
        btn_load = 1'b1;
        cyc(8);
        btn_load = 1'b0;
        cyc(10);
    endtask

    task automatic handshake();
        cons_ready = 1'b1;
        cyc(1);
        cons_ready = 1'b0;
    endtask

    int caps;
    int first;
    logic [1:0] prev;

    initial begin
        @(posedge clk);
        chk_en = 1'b1;
        cyc(3);
        reset_n = 1'b1;
        check("rst_a", a_out, 0);
        check("rst_phase", phase_led, 2'b01);
        check("rst_valid", operand_valid, 0);
        cyc(20);
        check("idle_valid", operand_valid, 0);
        check("idle_phase", phase_led, 2'b01);

        // Full load and handshake
        sw_in = 4'b0101;
        press();
        check("loadA_phase", phase_led, 2'b10);
        sw_in  = 4'b0011;
        cin_sw = 1'b1;
        press();
        cyc(5);
        check("full_a", a_out, 4'b0101);
        check("full_b", b_out, 4'b0011);
        check("full_c", c_out, 1);
        check("full_valid", operand_valid, 1);
        check("full_phase", phase_led, 2'b11);
        handshake();
        check("hs_valid", operand_valid, 0);
        check("hs_phase", phase_led, 2'b01);
        check("hs_a_hold", a_out, 4'b0101);

        // Press in PRESENT is ignored and not queued
        sw_in = 4'b0110;
        press();
        sw_in  = 4'b1001;
        cin_sw = 1'b0;
        press();
        sw_in = 4'b1111;
        press();
        check("ign_a", a_out, 4'b0110);
        check("ign_b", b_out, 4'b1001);
        check("ign_c", c_out, 0);
        check("ign_phase", phase_led, 2'b11);
        handshake();
        cyc(20);
        check("ign_noqueue_valid", operand_valid, 0);
        check("ign_noqueue_phase", phase_led, 2'b01);

        // Short glitch is rejected
        btn_load = 1'b1;
        cyc(3);
        btn_load = 1'b0;
        cyc(10);
        check("glitch_phase", phase_led, 2'b01);
        check("glitch_a", a_out, 4'b0110);

        // Bouncing button yields exactly one capture
        sw_in = 4'b0111;
        for (int i = 0; i < 10; i++) begin
            btn_load = ~btn_load;
            cyc(1);
        end
        btn_load = 1'b1;
        caps  = 0;
        first = -1;
        prev  = phase_led;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            if (phase_led != prev) begin
                caps++;
                first = i + 1;
            end
            prev = phase_led;
        end
        btn_load = 1'b0;
        cyc(10);
        check("bounce_caps", caps, 1);
        check("bounce_latency_ok", (first > 0 && first <= DB + 4) ? 1 : 0, 1);
        check("bounce_a", a_out, 4'b0111);
        check("bounce_phase", phase_led, 2'b10);

        // Mid-load reset abandons the partial set
        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        sw_in = 4'b1010;
        press();
        check("mid_a", a_out, 4'b1010);
        check("mid_phase", phase_led, 2'b10);
        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        check("mid_rst_a", a_out, 0);
        check("mid_rst_phase", phase_led, 2'b01);
        cyc(10);
        check("mid_noevent_phase", phase_led, 2'b01);
        sw_in = 4'b1100;
        press();
        check("mid_next_a", a_out, 4'b1100);
        check("mid_next_phase", phase_led, 2'b10);

        // Button held through reset release gives one event
        sw_in    = 4'b0001;
        btn_load = 1'b1;
        reset_n  = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        cyc(12);
        check("held_a", a_out, 4'b0001);
        check("held_phase", phase_led, 2'b10);
        btn_load = 1'b0;
        cyc(10);
        check("held_once_phase", phase_led, 2'b10);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sw_operand_loader.md
SW_OPERAND_LOADER -- requirements
Module: sw_operand_loader

Interface
REQ-001 The module SHALL have parameter DATA_SIZE, default 4, meaning the operand width in bits.
REQ-002 The module SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the number of stable synchronized cycles required to accept a button level change (legal range 2 or more).
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 sw_in  input  DATA_SIZE  raw slide-switch operand value; asynchronous to clk.
REQ-006 cin_sw  input  1  raw slide-switch carry-in value; asynchronous to clk.
REQ-007 btn_load  input  1  raw push-button, active-high, bouncing, asynchronous to clk.
REQ-008 cons_ready  input  1  consumer ready for the operand set.
REQ-009 a_out  output  DATA_SIZE  captured operand A.
REQ-010 b_out  output  DATA_SIZE  captured operand B.
REQ-011 c_out  output  1  captured carry-in.
REQ-012 operand_valid  output  1  a_out, b_out and c_out form a complete set.
REQ-013 phase_led  output  2  current phase: 01 LOAD_A, 10 LOAD_B, 11 PRESENT.

Function
REQ-014 sw_in, cin_sw and btn_load SHALL each pass through a 2-flop synchronizer before any other use.
REQ-015 Debouncer: a counter SHALL clear whenever the synchronized button equals the debounced level, and SHALL increment otherwise.
REQ-016 When the counter is DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level SHALL take the synchronized value and the counter SHALL clear.
REQ-017 The counter width SHALL be $clog2(DEBOUNCE_CYCLES+1), and the counter SHALL never wrap.
REQ-018 A press event SHALL be a registered, single-cycle pulse on each 0->1 transition of the debounced level; the 1->0 transition produces no event.
REQ-019 The FSM SHALL have exactly three states: LOAD_A, LOAD_B and PRESENT.
REQ-020 In LOAD_A, a press event SHALL capture synchronized sw_in into a_out and move the FSM to LOAD_B.
REQ-021 In LOAD_B, a press event SHALL capture synchronized sw_in into b_out and synchronized cin_sw into c_out, and move the FSM to PRESENT.
REQ-022 operand_valid SHALL be registered and SHALL be 1 exactly while the FSM is in PRESENT, starting the cycle after the LOAD_B capture.
REQ-023 In PRESENT, a clock edge with cons_ready=1 SHALL complete the handshake; operand_valid falls and the FSM returns to LOAD_A on that edge.
REQ-024 In PRESENT with cons_ready=0, a_out, b_out, c_out and operand_valid SHALL hold unchanged indefinitely.
REQ-025 Press events in PRESENT SHALL be ignored and SHALL NOT be queued.
REQ-026 a_out, b_out and c_out SHALL hold their values after the handshake until next overwritten by a capture.
REQ-027 cons_ready outside PRESENT SHALL have no effect.
REQ-028 phase_led SHALL be driven directly from the FSM state with no extra latency.
REQ-029 A switch change SHALL affect only captures made after it has passed the synchronizer; captures SHALL never use unsynchronized values.

Reset
REQ-030 While reset_n=0 at a clock edge, the FSM SHALL go to LOAD_A, and a_out, b_out, c_out and operand_valid SHALL go to 0.
REQ-031 While reset_n=0 at a clock edge, the synchronizer flops, debounced level, counter and press-event register SHALL go to 0, and phase_led SHALL read 01.
REQ-032 Reset asserted mid-operation (any state, counter mid-count, or during a handshake) SHALL abandon all partial captures, with no event generated on reset release.
REQ-033 If btn_load is held high through reset release, one press event SHALL be generated after DEBOUNCE_CYCLES stable cycles.

Verification (DEBOUNCE_CYCLES=4, DATA_SIZE=4)
REQ-034 Reset: hold reset_n=0 for 3 cycles, then release -> all outputs 0, phase_led=01, no operand_valid for 20 cycles with btn_load=0.
REQ-035 Full load: sw_in=0101 + clean press; then sw_in=0011, cin_sw=1 + clean press; cons_ready=0 -> a_out=0101, b_out=0011, c_out=1, operand_valid=1, phase_led=11 and held; cons_ready=1 for one cycle -> operand_valid=0, phase_led=01.
REQ-036 Bounce: toggle btn_load every cycle for 10 cycles, then hold 1 for 8 cycles -> exactly one capture, within DEBOUNCE_CYCLES+4 cycles of the final stable edge.
REQ-037 Glitch rejection: btn_load high for 3 cycles (less than DEBOUNCE_CYCLES after sync), then low -> no press event, phase unchanged.
REQ-038 Ignored press: in PRESENT with cons_ready=0, apply press with sw_in=1111 -> a_out, b_out and c_out unchanged, no second set after the handshake.
REQ-039 Mid-load reset: capture A=1010, reach LOAD_B, assert reset_n=0 for 1 cycle -> a_out=0, phase_led=01, next press captures into a_out.
